rom_download_ctrl: RTL and testbench



---
 rtl/rom_dl_pkg.sv | 32 +++
 rtl/rom_dl_settle_timer.sv | 37 +++
 rtl/rom_download_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_rom_download_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_dl_pkg.sv
// -----------------------------------------------------------------------------
// rom_dl_pkg
// Shared types and constants for the ROM download controller.
//   dl_state_t     : controller state encoding
//   IDX_*          : hps_io download index values the controller understands
//   SETTLE_W       : width of the settle down-counter
//   settle_reload  : counter value loaded on SETTLE entry / reset request
// -----------------------------------------------------------------------------
package rom_dl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIPLOAD,
    SETTLE,
    RUN
  } dl_state_t;

  localparam logic [7:0] IDX_ROM  = 8'd0;
  localparam logic [7:0] IDX_MOD  = 8'd1;
  localparam logic [7:0] IDX_PROM = 8'd2;
  localparam logic [7:0] IDX_DIP  = 8'd254;

  localparam int SETTLE_W = 16;

  // The counter is loaded with cycles-1 and the RUN transition is taken on
  // the edge that observes zero, giving a hold of exactly 'cycles' clocks.
  function automatic logic [SETTLE_W-1:0] settle_reload(input int cycles);
    return SETTLE_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/rom_dl_settle_timer.sv
// -----------------------------------------------------------------------------
// rom_dl_settle_timer
// Loadable down-counter that stops at zero; done is high while the count is 0.
// Ports:
//   clk        : clock
//   reset      : asynchronous active-high reset (count -> 0)
//   load       : load load_value (has priority over dec)
//   load_value : value to load
//   dec        : decrement by one when non-zero
//   done       : count == 0
// -----------------------------------------------------------------------------
module rom_dl_settle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/rom_download_ctrl.sv
// -----------------------------------------------------------------------------
// rom_download_ctrl
// Sequences hps_io ioctl downloads into program ROM, colour PROM, the
// machine-select byte and the DIP switch bytes, and owns the core reset.
//
// Optional build macro: ROM_DL_CHECKSUM_EN adds output rom_sum, a 16-bit
// wrapping sum of all accepted index-0 bytes of the latest ROM download.
//
// Ports:
//   clk_sys        : system clock
//   reset          : asynchronous active-high reset
//   ioctl_download : download active (hps_io)
//   ioctl_wr       : one-cycle byte strobe
//   ioctl_addr     : byte address
//   ioctl_dout     : byte data
//   ioctl_index    : download index
//   reset_req      : menu/button reset request
//   dn_addr        : registered write address to memories
//   dn_data        : registered write data
//   rom_wr         : program ROM write pulse
//   prom_wr        : colour PROM write pulse
//   mod            : machine select byte
//   sw0..sw2       : DIP switch bytes
//   rom_sum        : (ROM_DL_CHECKSUM_EN only) ROM byte checksum
//   core_reset     : reset to CPU/video/audio
//   busy           : controller not in RUN
//   overflow       : sticky, a ROM/PROM byte was dropped as out of range
// -----------------------------------------------------------------------------
module rom_download_ctrl
  import rom_dl_pkg::*;
#(
  parameter int ROM_AW        = 16,
  parameter int PROM_AW       = 10,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  input  logic        reset_req,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        rom_wr,
  output logic        prom_wr,
  output logic [7:0]  mod,
  output logic [7:0]  sw0,
  output logic [7:0]  sw1,
  output logic [7:0]  sw2,
`ifdef ROM_DL_CHECKSUM_EN
  output logic [15:0] rom_sum,
`endif
  output logic        core_reset,
  output logic        busy,
  output logic        overflow
);

  localparam logic [SETTLE_W-1:0] SETTLE_RELOAD = settle_reload(SETTLE_CYCLES);

  dl_state_t   state_reg;
  logic        dl_prev_reg;
  logic        active_reg;   // current download is being accepted
  logic [7:0]  index_reg;

  logic        rise;
  logic        fall;
  logic        rise_load;    // download rise that enters LOAD
  logic [7:0]  eff_index;
  logic        wr_accept;
  logic        rom_in_range;
  logic        prom_in_range;
  logic        rom_hit;
  logic        rom_oor;
  logic        prom_hit;
  logic        prom_oor;
  logic        mod_hit;
  logic        dip_hit;
  logic        settle_load;
  logic        settle_dec;
  logic        settle_done;

  // ---------------------------------------------------------------------------
  // Download edge detection and write decode
  // ---------------------------------------------------------------------------
  always_comb begin
    rise      = ioctl_download & ~dl_prev_reg;
    fall      = ~ioctl_download & dl_prev_reg;
    rise_load = rise && (ioctl_index != IDX_DIP);
    // A strobe coincident with the rise belongs to the new download.
    eff_index = rise ? ioctl_index : index_reg;
    wr_accept = ioctl_wr && ioctl_download && (rise || active_reg);

    rom_in_range  = ((ioctl_addr >> ROM_AW) == '0);
    prom_in_range = ((ioctl_addr >> PROM_AW) == '0);

    rom_hit  = wr_accept && (eff_index == IDX_ROM)  &&  rom_in_range;
    rom_oor  = wr_accept && (eff_index == IDX_ROM)  && !rom_in_range;
    prom_hit = wr_accept && (eff_index == IDX_PROM) &&  prom_in_range;
    prom_oor = wr_accept && (eff_index == IDX_PROM) && !prom_in_range;
    mod_hit  = wr_accept && (eff_index == IDX_MOD)  && (ioctl_addr == '0);
    dip_hit  = wr_accept && (eff_index == IDX_DIP)  && (ioctl_addr[24:3] == '0);
  end

  // ---------------------------------------------------------------------------
  // Settle timer control. A non-DIP download rise takes priority over a
  // reset request; a DIP rise in RUN also suppresses it (DIPLOAD ignores it).
  // ---------------------------------------------------------------------------
  always_comb begin
    settle_load = 1'b0;
    unique case (state_reg)
      LOAD:    settle_load = fall;
      SETTLE:  settle_load = reset_req && !rise_load;
      RUN:     settle_load = reset_req && !rise;
      default: settle_load = 1'b0;
    endcase
    settle_dec = (state_reg == SETTLE);
  end

  rom_dl_settle_timer #(
    .W (SETTLE_W)
  ) u_settle_timer (
    .clk        (clk_sys),
    .reset      (reset),
    .load       (settle_load),
    .load_value (SETTLE_RELOAD),
    .dec        (settle_dec),
    .done       (settle_done)
  );

  // ---------------------------------------------------------------------------
  // Controller FSM with registered core_reset / busy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      core_reset  <= 1'b1;
      busy        <= 1'b1;
      // Reset to 1 so a download still in progress across a reset is not
      // seen as a fresh rise; its remaining bytes are ignored.
      dl_prev_reg <= 1'b1;
      active_reg  <= 1'b0;
      index_reg   <= IDX_ROM;
    end else begin
      dl_prev_reg <= ioctl_download;
      if (rise) begin
        index_reg  <= ioctl_index;
        active_reg <= 1'b1;
      end else if (fall) begin
        active_reg <= 1'b0;
      end

      unique case (state_reg)
        IDLE: begin
          // Index 254 here is handled in place: only the sw bytes change.
          if (rise_load) begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          if (fall) begin
            state_reg <= SETTLE;
          end
        end
        DIPLOAD: begin
          if (fall) begin
            state_reg <= RUN;
            busy      <= 1'b0;
          end
        end
        SETTLE: begin
          if (rise_load) begin
            state_reg <= LOAD;
          end else if (!reset_req && settle_done) begin
            state_reg  <= RUN;
            core_reset <= 1'b0;
            busy       <= 1'b0;
          end
        end
        RUN: begin
          if (rise_load) begin
            state_reg  <= LOAD;
            core_reset <= 1'b1;
            busy       <= 1'b1;
          end else if (rise) begin
            // DIP switch update while running: the game keeps going.
            state_reg <= DIPLOAD;
            busy      <= 1'b1;
          end else if (reset_req) begin
            state_reg  <= SETTLE;
            core_reset <= 1'b1;
            busy       <= 1'b1;
          end
        end
        default: begin
          state_reg  <= IDLE;
          core_reset <= 1'b1;
          busy       <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered write path and captured configuration bytes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rom_wr   <= 1'b0;
      prom_wr  <= 1'b0;
      dn_addr  <= '0;
      dn_data  <= '0;
      mod      <= '0;
      sw0      <= '0;
      sw1      <= '0;
      sw2      <= '0;
      overflow <= 1'b0;
    end else begin
      rom_wr  <= rom_hit;
      prom_wr <= prom_hit;
      if (rom_hit || prom_hit) begin
        dn_addr <= ioctl_addr[15:0];
        dn_data <= ioctl_dout;
      end
      if (mod_hit) begin
        mod <= ioctl_dout;
      end
      if (dip_hit) begin
        unique case (ioctl_addr[2:0])
          3'd0:    sw0 <= ioctl_dout;
          3'd1:    sw1 <= ioctl_dout;
          3'd2:    sw2 <= ioctl_dout;
          default: ;
        endcase
      end
      // Clear on LOAD entry, but a dropped byte in the entry cycle still sets.
      if (rise_load) begin
        overflow <= 1'b0;
      end
      if (rom_oor || prom_oor) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef ROM_DL_CHECKSUM_EN
  logic sum_clear;
  assign sum_clear = rise_load && (ioctl_index == IDX_ROM);

  // Only LOAD accepts index-0 bytes, so the sum freezes once SETTLE is entered.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rom_sum <= '0;
    end else if (rom_hit) begin
      rom_sum <= (sum_clear ? 16'h0000 : rom_sum) + {8'h00, ioctl_dout};
    end else if (sum_clear) begin
      rom_sum <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_rom_download_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rom_download_ctrl
// Directed bench for rom_download_ctrl. Inputs are driven and outputs sampled
// on the falling clock edge. Build with ROM_DL_CHECKSUM_EN to also cover
// rom_sum.
// -----------------------------------------------------------------------------
module tb_rom_download_ctrl;

  localparam int SC = 16;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        reset_req;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        rom_wr;
  logic        prom_wr;
  logic [7:0]  mod;
  logic [7:0]  sw0;
  logic [7:0]  sw1;
  logic [7:0]  sw2;
  logic        core_reset;
  logic        busy;
  logic        overflow;
`ifdef ROM_DL_CHECKSUM_EN
  logic [15:0] rom_sum;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  rom_download_ctrl #(
    .ROM_AW        (16),
    .PROM_AW       (10),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .reset_req      (reset_req),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .rom_wr         (rom_wr),
    .prom_wr        (prom_wr),
    .mod            (mod),
    .sw0            (sw0),
    .sw1            (sw1),
    .sw2            (sw2),
`ifdef ROM_DL_CHECKSUM_EN
    .rom_sum        (rom_sum),
`endif
    .core_reset     (core_reset),
    .busy           (busy),
    .overflow       (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-22s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Called at a falling edge: one-cycle strobe, then check the pulse one
  // cycle later and its absence the cycle after that.
  task automatic wr_byte(input string tag, input logic [24:0] addr, input logic [7:0] data,
                         input logic exp_rom, input logic exp_prom);
    ioctl_wr   = 1'b1;
    ioctl_addr = addr;
    ioctl_dout = data;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check({tag, ".rom_wr"}, {31'd0, rom_wr}, {31'd0, exp_rom});
    check({tag, ".prom_wr"}, {31'd0, prom_wr}, {31'd0, exp_prom});
    if (exp_rom || exp_prom) begin
      check({tag, ".dn_addr"}, {16'd0, dn_addr}, {16'd0, addr[15:0]});
      check({tag, ".dn_data"}, {24'd0, dn_data}, {24'd0, data});
    end
    @(negedge clk_sys);
    check({tag, ".pulse_end"}, {30'd0, rom_wr, prom_wr}, 32'd0);
  endtask

  initial begin
    int pulses;
    int runs;

    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = '0;
    reset_req      = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;

    // ---- Power-on state, idle with no download ----
    check("por.core_reset", {31'd0, core_reset}, 32'd1);
    check("por.busy", {31'd0, busy}, 32'd1);
    check("por.mod", {24'd0, mod}, 32'd0);
    check("por.overflow", {31'd0, overflow}, 32'd0);
    check("por.dn_addr", {16'd0, dn_addr}, 32'd0);
    pulses = 0;
    runs   = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk_sys);
      if (rom_wr || prom_wr) pulses++;
      if (!core_reset || !busy) runs++;
    end
    check("idle.pulses", pulses, 32'd0);
    check("idle.not_run_cycles", runs, 32'd0);

    // ---- Index-0 ROM download, first strobe coincident with the rise ----
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    wr_byte("rom0", 25'd0, 8'hAA, 1'b1, 1'b0);
    check("rom.busy", {31'd0, busy}, 32'd1);
    wr_byte("rom1", 25'd1, 8'h55, 1'b1, 1'b0);
    wr_byte("rom2", 25'd2, 8'h01, 1'b1, 1'b0);
    wr_byte("rom3", 25'd3, 8'hFF, 1'b1, 1'b0);
    ioctl_download = 1'b0;
    repeat (SC) @(negedge clk_sys);
    check("rom.settle_hold", {31'd0, core_reset}, 32'd1);
    @(negedge clk_sys);
    check("rom.settle_release", {31'd0, core_reset}, 32'd0);
    check("rom.busy_run", {31'd0, busy}, 32'd0);
    check("rom.overflow", {31'd0, overflow}, 32'd0);
`ifdef ROM_DL_CHECKSUM_EN
    check("rom.rom_sum", {16'd0, rom_sum}, 32'h01FF);
`endif

    // ---- Index-254 DIP download while running ----
    ioctl_download = 1'b1;
    ioctl_index    = 8'd254;
    @(negedge clk_sys);
    check("dip.busy", {31'd0, busy}, 32'd1);
    check("dip.core_reset", {31'd0, core_reset}, 32'd0);
    wr_byte("dip0", 25'd0, 8'h12, 1'b0, 1'b0);
    wr_byte("dip1", 25'd1, 8'h34, 1'b0, 1'b0);
    wr_byte("dip2", 25'd2, 8'h56, 1'b0, 1'b0);
    wr_byte("dip3", 25'd3, 8'h78, 1'b0, 1'b0);
    check("dip.core_reset_mid", {31'd0, core_reset}, 32'd0);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("dip.busy_done", {31'd0, busy}, 32'd0);
    check("dip.core_reset_done", {31'd0, core_reset}, 32'd0);
    check("dip.sw0", {24'd0, sw0}, 32'h12);
    check("dip.sw1", {24'd0, sw1}, 32'h34);
    check("dip.sw2", {24'd0, sw2}, 32'h56);

    // ---- Index-2 PROM download with an out-of-range byte ----
    ioctl_download = 1'b1;
    ioctl_index    = 8'd2;
    @(negedge clk_sys);
    check("prom.core_reset", {31'd0, core_reset}, 32'd1);
    wr_byte("prom1023", 25'd1023, 8'hC3, 1'b0, 1'b1);
    check("prom.ovf_before", {31'd0, overflow}, 32'd0);
    wr_byte("prom1024", 25'd1024, 8'h3C, 1'b0, 1'b0);
    check("prom.ovf_after", {31'd0, overflow}, 32'd1);
    check("prom.dn_addr_hold", {16'd0, dn_addr}, 32'h03FF);
    check("prom.dn_data_hold", {24'd0, dn_data}, 32'hC3);
    ioctl_download = 1'b0;
    repeat (SC + 1) @(negedge clk_sys);
    check("prom.run", {31'd0, core_reset}, 32'd0);
    check("prom.ovf_in_run", {31'd0, overflow}, 32'd1);

    // ---- Index-1 machine select; LOAD entry clears overflow ----
    ioctl_download = 1'b1;
    ioctl_index    = 8'd1;
    @(negedge clk_sys);
    check("mod.ovf_cleared", {31'd0, overflow}, 32'd0);
    wr_byte("mod0", 25'd0, 8'h5A, 1'b0, 1'b0);
    check("mod.value", {24'd0, mod}, 32'h5A);
    wr_byte("mod1", 25'd1, 8'h77, 1'b0, 1'b0);
    check("mod.addr1_ignored", {24'd0, mod}, 32'h5A);
    ioctl_download = 1'b0;
    repeat (SC + 1) @(negedge clk_sys);
    check("mod.run", {31'd0, core_reset}, 32'd0);

    // ---- reset_req in RUN, then again at settle count 5 ----
    reset_req = 1'b1;
    @(negedge clk_sys);
    reset_req = 1'b0;
    check("rreq.core_reset", {31'd0, core_reset}, 32'd1);
    check("rreq.busy", {31'd0, busy}, 32'd1);
    repeat (SC - 6) @(negedge clk_sys);
    reset_req = 1'b1;
    @(negedge clk_sys);
    reset_req = 1'b0;
    repeat (SC - 1) @(negedge clk_sys);
    check("rreq.reload_hold", {31'd0, core_reset}, 32'd1);
    @(negedge clk_sys);
    check("rreq.release", {31'd0, core_reset}, 32'd0);

    // ---- Asynchronous reset in the middle of an index-0 download ----
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    wr_byte("arst0", 25'd0, 8'h11, 1'b1, 1'b0);
    wr_byte("arst1", 25'd1, 8'h22, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check("arst.core_reset", {31'd0, core_reset}, 32'd1);
    check("arst.busy", {31'd0, busy}, 32'd1);
    check("arst.mod", {24'd0, mod}, 32'd0);
    check("arst.sw0", {24'd0, sw0}, 32'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    wr_byte("arst_late", 25'd2, 8'h33, 1'b0, 1'b0);
    ioctl_download = 1'b0;
    repeat (SC + 4) @(negedge clk_sys);
    check("arst.idle_hold", {31'd0, core_reset}, 32'd1);

    // ---- DIP download in IDLE is handled in place ----
    ioctl_download = 1'b1;
    ioctl_index    = 8'd254;
    wr_byte("idip0", 25'd0, 8'h99, 1'b0, 1'b0);
    check("idip.sw0", {24'd0, sw0}, 32'h99);
    check("idip.busy", {31'd0, busy}, 32'd1);
    ioctl_download = 1'b0;
    @(negedge clk_sys);

    // ---- New rise re-enables ROM writes ----
    ioctl_download = 1'b1;
    ioctl_index    = 8'd0;
    @(negedge clk_sys);
    wr_byte("newdl", 25'd5, 8'h44, 1'b1, 1'b0);
`ifdef ROM_DL_CHECKSUM_EN
    check("newdl.rom_sum", {16'd0, rom_sum}, 32'h0044);
`endif
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
